condition_wait_mux: RTL and testbench
=====================================

# condition_wait_mux

Parametrised condition selector for the microprogrammed control unit. It picks one of NUM_COND status conditions (memory complete, branch condition, annul, trap, and others), with optional inversion and sticky capture, and returns a registered result to the microsequencer. A wait mode holds the sequencer until the selected condition becomes true, with an optional timeout.

## Interface
- NUM_COND, 8: number of condition inputs.
- SEL_W, 3: width of Cond_Select; indices >= NUM_COND are out of range.
- TIMEOUT_W, 8: width of the wait counter and Timeout_Limit.
- STICKY_MASK, 8'b0000_1000: a set bit makes that condition sticky (bit 3 = Trap).
- Clk  input  1  single clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Cond_In  input  NUM_COND  raw conditions; bit 0 Memory_Operation_Complete, 1 Branch_Condition, 2 Branch_Annul, 3 Trap.
- Cond_Select  input  SEL_W  condition index; sampled on Eval.
- Invert  input  1  invert the selected condition; sampled on Eval.
- Wait_Mode  input  1  1 = wait until true, 0 = evaluate immediately; sampled on Eval.
- Eval  input  1  single-cycle evaluate request.
- Sticky_Clear  input  1  clears all sticky bits.
- Timeout_Limit  input  TIMEOUT_W  maximum wait cycles; 0 = no timeout.
- Condition  output  1  registered result.
- Cond_Valid  output  1  one-cycle pulse; Condition is valid in that cycle.
- Busy  output  1  high while in WAIT.
- Timeout  output  1  one-cycle pulse alongside Cond_Valid when the wait expired.

## Operation
- Effective condition, combinational:
  - eff[i] = Cond_In[i] | (STICKY_MASK[i] & sticky[i]).
  - sel = (index < NUM_COND ? eff[index] : 0) ^ inv.
- Sticky register:
  - Each clock: sticky <= Sticky_Clear ? 0 : (sticky | (Cond_In & STICKY_MASK)).
  - Clear has priority. A condition asserted in the same cycle as Sticky_Clear is not captured, but it still appears in eff through Cond_In.
- FSM state IDLE:
  - Eval with Wait_Mode=0, or with Wait_Mode=1 and sel=1: Condition <= sel, Cond_Valid <= 1, stay in IDLE.
  - Eval with Wait_Mode=1 and sel=0: latch Cond_Select and Invert, clear the counter, go to WAIT.
- FSM state WAIT (Busy=1):
  - Re-evaluate sel from the latched index and invert flag each cycle.
  - sel=1: Condition <= 1, Cond_Valid <= 1, go to IDLE.
  - Otherwise, with the timeout enabled and Timeout_Limit != 0: increment the counter. When counter == Timeout_Limit-1 and sel=0, drive Condition <= 0, Cond_Valid <= 1, Timeout <= 1, go to IDLE.
  - Timeout_Limit is read live each cycle, not latched.
- Eval while Busy=1 is ignored (no queueing). Cond_Select and Invert changes during WAIT have no effect.
- A wait on an out-of-range index with Invert=0 can only terminate by timeout or Reset.
- Counter arithmetic: unsigned TIMEOUT_W bits, no wrap. It is compared against the limit before incrementing.

## Timing
- Reset values: Condition=0, Cond_Valid=0, Busy=0, Timeout=0, state IDLE, sticky=0, counter=0.
- Immediate evaluation: Eval in cycle n gives Cond_Valid and Condition in cycle n+1.
- Wait: if sel is first true in WAIT cycle k, Cond_Valid is high in k+1 and Busy is low in k+1.
- Timeout: with Timeout_Limit=L, Cond_Valid/Timeout rise exactly L cycles after Busy rises.
- Cond_Valid and Timeout are single-cycle pulses. Condition holds its value until the next Cond_Valid.
- Busy rises the cycle after the Eval that enters WAIT.
- Reset mid-wait aborts immediately: no Cond_Valid and no Timeout pulse.
- A condition pulse lasting one cycle is seen in WAIT only if sticky. Non-sticky conditions must be level-held.

## Configuration
- COND_TIMEOUT_EN defined: the timeout counter and Timeout output are implemented as above.
- COND_TIMEOUT_EN undefined: no counter is built, Timeout is tied to 0, Timeout_Limit is ignored, and WAIT exits only on sel=1 or Reset.

## Test plan
- Immediate select: Cond_In=8'b0000_0010, Eval with Cond_Select=1, Invert=0 -> next cycle Condition=1, Cond_Valid=1. Repeat with Invert=1 -> Condition=0.
- Wait success: Cond_In=0, Eval with Cond_Select=0, Wait_Mode=1; raise bit 0 after 5 cycles -> Busy high for 6 cycles, then Condition=1 and Cond_Valid pulse, Timeout=0.
- Timeout (COND_TIMEOUT_EN): Timeout_Limit=4, wait on bit 2 held 0 -> Cond_Valid=1, Timeout=1, Condition=0 four cycles after Busy rises. With Timeout_Limit=0, still Busy after 300 cycles.
- Sticky trap: one-cycle pulse on Cond_In[3], then Eval on index 3 -> Condition=1. Sticky_Clear, then Eval -> Condition=0. Clear coincident with a pulse -> not captured.
- Out-of-range/ignored Eval: Cond_Select=7 with NUM_COND=4, Invert=1 -> Condition=1. Eval during Busy -> no extra Cond_Valid.
- Reset mid-wait: assert Reset in WAIT -> next cycle Busy=0, no Cond_Valid, all outputs 0.

Source files
------------

// File: rtl/condition_wait_mux.sv
// Condition selector for the microsequencer: selects one status condition (optionally inverted/sticky)
// and either returns it immediately or waits for it. Build with COND_TIMEOUT_EN to add the wait timeout.
module condition_wait_mux #(
  parameter int unsigned         NUM_COND    = 8,
  parameter int unsigned         SEL_W       = 3,
  parameter int unsigned         TIMEOUT_W   = 8,
  parameter logic [NUM_COND-1:0] STICKY_MASK = NUM_COND'(8'b0000_1000)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_COND-1:0]  Cond_In,
  input  logic [SEL_W-1:0]     Cond_Select,
  input  logic                 Invert,
  input  logic                 Wait_Mode,
  input  logic                 Eval,
  input  logic                 Sticky_Clear,
  input  logic [TIMEOUT_W-1:0] Timeout_Limit,
  output logic                 Condition,
  output logic                 Cond_Valid,
  output logic                 Busy,
  output logic                 Timeout
);

  // Selection space padded to the full index range so out-of-range indices read as 0.
  localparam int unsigned SEL_N = 1 << SEL_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]          state;
  logic [0:0]          state_n;
  logic [NUM_COND-1:0] sticky;
  logic [NUM_COND-1:0] eff;
  logic [SEL_N-1:0]    eff_ext;
  logic [SEL_W-1:0]    wait_sel;
  logic [SEL_W-1:0]    wait_sel_n;
  logic                wait_inv;
  logic                wait_inv_n;
  logic                sel_live;
  logic                sel_wait;
  logic                condition_n;
  logic                cond_valid_n;
`ifdef COND_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [TIMEOUT_W-1:0] wait_cnt_n;
  logic                 timeout_n;
`endif

  assign eff = Cond_In | (STICKY_MASK & sticky);

  always_comb begin
    eff_ext = '0;
    eff_ext[NUM_COND-1:0] = eff;
  end

  assign sel_live = eff_ext[Cond_Select] ^ Invert;
  assign sel_wait = eff_ext[wait_sel] ^ wait_inv;

  // Sticky capture; a clear wins over a coincident capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sticky <= '0;
    end else if (Sticky_Clear) begin
      sticky <= '0;
    end else begin
      sticky <= sticky | (Cond_In & STICKY_MASK);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    condition_n  = Condition;
    cond_valid_n = 1'b0;
    wait_sel_n   = wait_sel;
    wait_inv_n   = wait_inv;
`ifdef COND_TIMEOUT_EN
    wait_cnt_n   = wait_cnt;
    timeout_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (Eval) begin
          if (!Wait_Mode || sel_live) begin
            condition_n  = sel_live;
            cond_valid_n = 1'b1;
          end else begin
            wait_sel_n = Cond_Select;
            wait_inv_n = Invert;
            state_n    = WAIT;
`ifdef COND_TIMEOUT_EN
            wait_cnt_n = '0;
`endif
          end
        end
      end
      WAIT: begin
        if (sel_wait) begin
          condition_n  = 1'b1;
          cond_valid_n = 1'b1;
          state_n      = IDLE;
`ifdef COND_TIMEOUT_EN
        end else if (Timeout_Limit != '0) begin
          // Limit is read live; compare before incrementing, saturate rather than wrap.
          if (wait_cnt == Timeout_Limit - TIMEOUT_W'(1)) begin
            condition_n  = 1'b0;
            cond_valid_n = 1'b1;
            timeout_n    = 1'b1;
            state_n      = IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt_n = wait_cnt + TIMEOUT_W'(1);
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered outputs and latched wait context.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Condition  <= 1'b0;
      Cond_Valid <= 1'b0;
      Busy       <= 1'b0;
      wait_sel   <= '0;
      wait_inv   <= 1'b0;
    end else begin
      Condition  <= condition_n;
      Cond_Valid <= cond_valid_n;
      Busy       <= (state_n == WAIT);
      wait_sel   <= wait_sel_n;
      wait_inv   <= wait_inv_n;
    end
  end

`ifdef COND_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_cnt <= '0;
      Timeout  <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_n;
      Timeout  <= timeout_n;
    end
  end
`else
  logic unused_limit;
  assign unused_limit = ^Timeout_Limit;
  assign Timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_condition_wait_mux.sv
// Directed bench for condition_wait_mux: a default instance plus a NUM_COND=4 instance for out-of-range selects.
module tb_condition_wait_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cond_in;
  logic [2:0] cond_select;
  logic       invert;
  logic       wait_mode;
  logic       eval;
  logic       sticky_clear;
  logic [7:0] timeout_limit;
  logic       condition, cond_valid, busy, timeout;
  logic       condition4, cond_valid4, busy4, timeout4;
  logic [3:0] outs, outs4;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  assign outs  = {cond_valid, condition, busy, timeout};
  assign outs4 = {cond_valid4, condition4, busy4, timeout4};

  condition_wait_mux dut (
    .Clk(clk), .Reset(reset), .Cond_In(cond_in), .Cond_Select(cond_select),
    .Invert(invert), .Wait_Mode(wait_mode), .Eval(eval), .Sticky_Clear(sticky_clear),
    .Timeout_Limit(timeout_limit), .Condition(condition), .Cond_Valid(cond_valid),
    .Busy(busy), .Timeout(timeout)
  );

  condition_wait_mux #(.NUM_COND(4), .SEL_W(3), .TIMEOUT_W(8), .STICKY_MASK(4'b1000)) dut4 (
    .Clk(clk), .Reset(reset), .Cond_In(cond_in[3:0]), .Cond_Select(cond_select),
    .Invert(invert), .Wait_Mode(wait_mode), .Eval(eval), .Sticky_Clear(sticky_clear),
    .Timeout_Limit(timeout_limit), .Condition(condition4), .Cond_Valid(cond_valid4),
    .Busy(busy4), .Timeout(timeout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eval_once(input logic [2:0] s, input logic inv, input logic wm);
    cond_select = s;
    invert      = inv;
    wait_mode   = wm;
    eval        = 1'b1;
    tick();
    eval        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    vectors++;
    if (outs !== 4'b0000) begin miscompares++; $display("FAIL reset_outs: got %b want 0000", outs); end
    vectors++;
    if (outs4 !== 4'b0000) begin miscompares++; $display("FAIL reset_outs4: got %b want 0000", outs4); end
    tick();
    vectors++;
    if (outs !== 4'b0000) begin miscompares++; $display("FAIL reset_idle: got %b want 0000", outs); end
  endtask

  task automatic test_immediate();
    cond_in = 8'b0000_0010;
    eval_once(3'd1, 1'b0, 1'b0);
    vectors++;
    if (outs !== 4'b1100) begin miscompares++; $display("FAIL imm_sel1: got %b want 1100", outs); end
    tick();
    vectors++;
    if (outs !== 4'b0100) begin miscompares++; $display("FAIL imm_pulse_hold: got %b want 0100", outs); end
    eval_once(3'd1, 1'b1, 1'b0);
    vectors++;
    if (outs !== 4'b1000) begin miscompares++; $display("FAIL imm_invert: got %b want 1000", outs); end
    eval_once(3'd0, 1'b0, 1'b0);
    vectors++;
    if (outs !== 4'b1000) begin miscompares++; $display("FAIL imm_sel0: got %b want 1000", outs); end
    eval_once(3'd1, 1'b0, 1'b1);
    vectors++;
    if (outs !== 4'b1100) begin miscompares++; $display("FAIL imm_wait_true: got %b want 1100", outs); end
    tick();
  endtask

  task automatic test_wait_success();
    int busy_cnt;
    cond_in = 8'h00;
    eval_once(3'd0, 1'b0, 1'b1);
    vectors++;
    if (outs !== 4'b0110) begin miscompares++; $display("FAIL wait_enter: got %b want 0110", outs); end
    busy_cnt = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      busy_cnt++;
      if (busy_cnt == 6) cond_in[0] = 1'b1;
      tick();
    end
    vectors++;
    if (busy_cnt !== 6) begin miscompares++; $display("FAIL wait_busy_len: got %0d want 6", busy_cnt); end
    vectors++;
    if (outs !== 4'b1100) begin miscompares++; $display("FAIL wait_done: got %b want 1100", outs); end
    tick();
    vectors++;
    if (outs !== 4'b0100) begin miscompares++; $display("FAIL wait_pulse: got %b want 0100", outs); end
    cond_in = 8'h00;
  endtask

  task automatic test_ignored_eval();
    cond_in = 8'h00;
    eval_once(3'd2, 1'b0, 1'b1);
    cond_select = 3'd1;
    invert      = 1'b1;
    wait_mode   = 1'b0;
    cond_in     = 8'b0000_0010;
    eval        = 1'b1;
    tick();
    eval        = 1'b0;
    vectors++;
    if (outs !== 4'b0110) begin miscompares++; $display("FAIL busy_eval_ignored: got %b want 0110", outs); end
    tick(); tick(); tick();
    vectors++;
    if (outs !== 4'b0110) begin miscompares++; $display("FAIL busy_latched_sel: got %b want 0110", outs); end
    cond_in = 8'b0000_0100;
    tick();
    vectors++;
    if (outs !== 4'b1100) begin miscompares++; $display("FAIL busy_latched_done: got %b want 1100", outs); end
    cond_in = 8'h00;
    invert  = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    logic seen;
    timeout_limit = 8'd4;
    cond_in = 8'h00;
    eval_once(3'd2, 1'b0, 1'b1);
    vectors++;
    if (outs !== 4'b0110) begin miscompares++; $display("FAIL to_enter: got %b want 0110", outs); end
`ifdef COND_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (outs !== 4'b0110) begin miscompares++; $display("FAIL to_waiting%0d: got %b want 0110", i, outs); end
    end
    tick();
    vectors++;
    if (outs !== 4'b1001) begin miscompares++; $display("FAIL to_expire: got %b want 1001", outs); end
    tick();
    vectors++;
    if (outs !== 4'b0000) begin miscompares++; $display("FAIL to_pulse: got %b want 0000", outs); end
    timeout_limit = 8'd0;
    eval_once(3'd2, 1'b0, 1'b1);
    seen = 1'b0;
    repeat (300) begin
      tick();
      seen = seen | cond_valid | timeout;
    end
    vectors++;
    if ({busy, seen} !== 2'b10) begin miscompares++; $display("FAIL to_limit0: busy/seen got %b want 10", {busy, seen}); end
`else
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | cond_valid | timeout;
    end
    vectors++;
    if ({busy, seen} !== 2'b10) begin miscompares++; $display("FAIL to_disabled: busy/seen got %b want 10", {busy, seen}); end
`endif
    cond_in = 8'b0000_0100;
    tick();
    vectors++;
    if (outs !== 4'b1100) begin miscompares++; $display("FAIL to_release: got %b want 1100", outs); end
    cond_in = 8'h00;
    timeout_limit = 8'd0;
    tick();
  endtask

  task automatic test_sticky();
    sticky_clear = 1'b1;
    tick();
    sticky_clear = 1'b0;
    cond_in = 8'b0000_1000;
    tick();
    cond_in = 8'h00;
    eval_once(3'd3, 1'b0, 1'b0);
    vectors++;
    if (outs !== 4'b1100) begin miscompares++; $display("FAIL sticky_capture: got %b want 1100", outs); end
    sticky_clear = 1'b1;
    tick();
    sticky_clear = 1'b0;
    eval_once(3'd3, 1'b0, 1'b0);
    vectors++;
    if (outs !== 4'b1000) begin miscompares++; $display("FAIL sticky_cleared: got %b want 1000", outs); end
    cond_in = 8'b0000_1000;
    sticky_clear = 1'b1;
    eval_once(3'd3, 1'b0, 1'b0);
    vectors++;
    if (outs !== 4'b1100) begin miscompares++; $display("FAIL sticky_coincident_live: got %b want 1100", outs); end
    cond_in = 8'h00;
    sticky_clear = 1'b0;
    eval_once(3'd3, 1'b0, 1'b0);
    vectors++;
    if (outs !== 4'b1000) begin miscompares++; $display("FAIL sticky_coincident_lost: got %b want 1000", outs); end
    cond_in = 8'b0000_0010;
    tick();
    cond_in = 8'h00;
    eval_once(3'd1, 1'b0, 1'b0);
    vectors++;
    if (outs !== 4'b1000) begin miscompares++; $display("FAIL nonsticky_pulse: got %b want 1000", outs); end
  endtask

  task automatic test_out_of_range();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cond_in = 8'hFF;
    eval_once(3'd7, 1'b1, 1'b0);
    vectors++;
    if ({cond_valid4, condition4} !== 2'b11) begin miscompares++; $display("FAIL oor_inv: got %b want 11", {cond_valid4, condition4}); end
    vectors++;
    if ({cond_valid, condition} !== 2'b10) begin miscompares++; $display("FAIL inrange_idx7_inv: got %b want 10", {cond_valid, condition}); end
    eval_once(3'd7, 1'b0, 1'b0);
    vectors++;
    if ({cond_valid4, condition4} !== 2'b10) begin miscompares++; $display("FAIL oor_plain: got %b want 10", {cond_valid4, condition4}); end
    vectors++;
    if ({cond_valid, condition} !== 2'b11) begin miscompares++; $display("FAIL inrange_idx7: got %b want 11", {cond_valid, condition}); end
    eval_once(3'd7, 1'b0, 1'b1);
    repeat (5) tick();
    vectors++;
    if (outs4 !== 4'b0010) begin miscompares++; $display("FAIL oor_wait_stuck: got %b want 0010", outs4); end
    cond_in = 8'h00;
  endtask

  task automatic test_reset_mid_wait();
    cond_in = 8'h00;
    eval_once(3'd0, 1'b0, 1'b1);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_wait_busy: got %b want 1", busy); end
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (outs !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_wait: got %b want 0000", outs); end
    vectors++;
    if (outs4 !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_wait4: got %b want 0000", outs4); end
    reset = 1'b0;
    tick();
    vectors++;
    if (outs !== 4'b0000) begin miscompares++; $display("FAIL rst_after: got %b want 0000", outs); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cond_in = 8'h00; cond_select = 3'd0; invert = 1'b0;
    wait_mode = 1'b0; eval = 1'b0; sticky_clear = 1'b0; timeout_limit = 8'd0;
    test_reset();
    test_immediate();
    test_wait_success();
    test_ignored_eval();
    test_timeout();
    test_sticky();
    test_out_of_range();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
